branch_control: RTL and testbench
=================================

BRANCH_CONTROL -- requirements
Module: branch_control

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 The block SHALL provide these ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- zero_flag  input  1  ALU zero result
- carry_flag  input  1  ALU carry out
- msb  input  1  sign bit of ALU result
- branch_label  input  16  signed word offset for conditional branches
- brtype  input  3  branch condition select
- jmp_ra  input  32  register jump target
- jmp_label  input  26  word index for absolute jump
- pc  input  32  current program counter
- counter_selector  input  2  next-PC source select
- incr_pc  output  32  registered next program counter
REQ-003 The block SHALL have no parameters.

Function
REQ-004 The block SHALL compute pc4 = pc + 4 (32-bit, modulo 2^32).
REQ-005 The block SHALL compute br_target = pc4 + (sign_extend_32(branch_label) << 2), modulo 2^32.
REQ-006 The block SHALL compute jmp_target = {pc4[31:28], jmp_label, 2'b00}.
REQ-007 The branch condition "taken" SHALL be selected by brtype:
- 0: never (plain sequential)
- 1: always (unconditional branch)
- 2: msb == 1 (less than zero)
- 3: zero_flag == 1
- 4: zero_flag == 0
- 5: carry_flag == 1
- 6: carry_flag == 0
- 7: never (reserved)
REQ-008 counter_selector SHALL select next_pc:
- 0: br_target if taken, else pc4
- 1: jmp_target
- 2: jmp_ra, passed unmodified with no alignment
- 3: hold the current incr_pc value
REQ-009 With counter_selector != 0, brtype and the flags SHALL have no effect.
REQ-010 On each rising clk edge with rst low, incr_pc SHALL load next_pc, giving one-cycle latency from inputs to output.
REQ-011 incr_pc SHALL change only on rising clk edges.
REQ-012 All arithmetic SHALL wrap silently: pc = 0xFFFFFFFC gives pc4 = 0. Negative offsets SHALL wrap below 0.

Reset
REQ-013 When rst is high at a rising clk edge, incr_pc SHALL become 0x00000000, overriding all other inputs.
REQ-014 incr_pc SHALL be 0 on the first edge after rst deasserts only if the sampled inputs select 0.
REQ-015 A rst asserted mid-sequence SHALL discard any pending selection. Normal updates SHALL resume on the first edge with rst low.

Verification
REQ-016 rst=1 for one edge, any inputs -> incr_pc = 0x00000000.
REQ-017 counter_selector=0, brtype=0, pc=0 -> incr_pc = 4 after one edge.
REQ-018 counter_selector=1, jmp_label=26, pc=0 -> incr_pc = 104 (0x68).
REQ-019 counter_selector=2, jmp_ra=1045, zero_flag=1, carry_flag=1 -> incr_pc = 1045.
REQ-020 counter_selector=0, brtype=1, branch_label=71, pc=0 -> incr_pc = 288. The same inputs with brtype=3 and zero_flag=0 -> incr_pc = 4.
REQ-021 counter_selector=0, brtype=2, msb=1, branch_label=0xFFFF, pc=100 -> incr_pc = 100. Then counter_selector=3 for two edges -> incr_pc stays 100.

Source files
------------

// File: rtl/branch_control_if.sv
// Bundle of branch/jump inputs and the registered next-PC output of branch_control.
interface branch_control_if;
  logic        zero_flag;
  logic        carry_flag;
  logic        msb;
  logic [15:0] branch_label;
  logic [2:0]  brtype;
  logic [31:0] jmp_ra;
  logic [25:0] jmp_label;
  logic [31:0] pc;
  logic [1:0]  counter_selector;
  logic [31:0] incr_pc;

  modport master (
    output zero_flag, carry_flag, msb, branch_label, brtype,
           jmp_ra, jmp_label, pc, counter_selector,
    input  incr_pc
  );

  modport slave (
    input  zero_flag, carry_flag, msb, branch_label, brtype,
           jmp_ra, jmp_label, pc, counter_selector,
    output incr_pc
  );
endinterface

// File: rtl/branch_control.sv
// Next-PC selection: sequential, conditional branch, absolute jump, register jump or hold,
// registered with one cycle of latency.
module branch_control (
  input logic             clk,
  input logic             rst,
  branch_control_if.slave bus
);
  logic [31:0] pc4, br_target, jmp_target, incr_pc_d, incr_pc_q;
  logic        taken;

  always_comb begin
    pc4        = bus.pc + 32'd4;
    br_target  = pc4 + {{14{bus.branch_label[15]}}, bus.branch_label, 2'b00};
    jmp_target = {pc4[31:28], bus.jmp_label, 2'b00};
  end

  always_comb begin
    taken = 1'b0;
    unique case (bus.brtype)
      3'd1:    taken = 1'b1;
      3'd2:    taken = bus.msb;
      3'd3:    taken = bus.zero_flag;
      3'd4:    taken = ~bus.zero_flag;
      3'd5:    taken = bus.carry_flag;
      3'd6:    taken = ~bus.carry_flag;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    incr_pc_d = incr_pc_q;
    unique case (bus.counter_selector)
      2'd0:    incr_pc_d = taken ? br_target : pc4;
      2'd1:    incr_pc_d = jmp_target;
      2'd2:    incr_pc_d = bus.jmp_ra;
      default: incr_pc_d = incr_pc_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) incr_pc_q <= 32'h0;
    else     incr_pc_q <= incr_pc_d;
  end

  assign bus.incr_pc = incr_pc_q;
endmodule

// File: tb/tb_branch_control.sv
// Table-driven bench for branch_control with a scoreboard queue of expected next-PC values.
module tb_branch_control;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_control_if bus();
  branch_control dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [1:0]  sel;
    logic [2:0]  bt;
    logic        z, c, m;
    logic [15:0] bl;
    logic [31:0] jra;
    logic [25:0] jl;
    logic [31:0] pc;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 20;
  vec_t        tbl [NV];
  logic [31:0] sbq [$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] last;
  bit          have_last = 0;

  function automatic vec_t mk(logic [1:0] sel, logic [2:0] bt, logic z, logic c, logic m,
                              logic [15:0] bl, logic [31:0] jra, logic [25:0] jl,
                              logic [31:0] pc, logic [31:0] exp);
    vec_t v;
    v.sel = sel; v.bt = bt; v.z = z; v.c = c; v.m = m;
    v.bl = bl; v.jra = jra; v.jl = jl; v.pc = pc; v.exp = exp;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: incr_pc=%h expected %h", name, act, exp);
    end
  endtask

  // Drive on the falling edge, confirm the output has not moved yet, then check after the rising edge.
  task automatic step(input vec_t v, input logic r, input string name);
    logic [31:0] e;
    @(negedge clk);
    rst = r;
    bus.counter_selector = v.sel; bus.brtype = v.bt;
    bus.zero_flag = v.z; bus.carry_flag = v.c; bus.msb = v.m;
    bus.branch_label = v.bl; bus.jmp_ra = v.jra; bus.jmp_label = v.jl; bus.pc = v.pc;
    sbq.push_back(r ? 32'h0 : v.exp);
    #2;
    if (have_last) check({name, "_stable"}, bus.incr_pc, last);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    check(name, bus.incr_pc, e);
    last = e;
    have_last = 1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    bus.counter_selector = '0; bus.brtype = '0; bus.zero_flag = 0; bus.carry_flag = 0;
    bus.msb = 0; bus.branch_label = '0; bus.jmp_ra = '0; bus.jmp_label = '0; bus.pc = '0;

    //            sel bt z c m bl        jra           jl          pc            exp
    tbl[0]  = mk(0, 0, 0,0,0, 16'h0000, 32'h0,        26'd0,      32'h0,        32'd4);
    tbl[1]  = mk(1, 0, 0,0,0, 16'h0000, 32'h0,        26'd26,     32'h0,        32'd104);
    tbl[2]  = mk(2, 0, 1,1,0, 16'h0000, 32'd1045,     26'd0,      32'h0,        32'd1045);
    tbl[3]  = mk(0, 1, 0,0,0, 16'd71,   32'h0,        26'd0,      32'h0,        32'd288);
    tbl[4]  = mk(0, 3, 0,0,0, 16'd71,   32'h0,        26'd0,      32'h0,        32'd4);
    tbl[5]  = mk(0, 2, 0,0,1, 16'hFFFF, 32'h0,        26'd0,      32'd100,      32'd100);
    tbl[6]  = mk(0, 3, 1,0,0, 16'd71,   32'h0,        26'd0,      32'h0,        32'd288);
    tbl[7]  = mk(0, 4, 0,0,0, 16'd1,    32'h0,        26'd0,      32'h1000,     32'h1008);
    tbl[8]  = mk(0, 4, 1,0,0, 16'd1,    32'h0,        26'd0,      32'h1000,     32'h1004);
    tbl[9]  = mk(0, 5, 0,1,0, 16'd2,    32'h0,        26'd0,      32'h0,        32'd12);
    tbl[10] = mk(0, 6, 0,1,0, 16'd2,    32'h0,        26'd0,      32'h0,        32'd4);
    tbl[11] = mk(0, 6, 0,0,0, 16'd2,    32'h0,        26'd0,      32'h0,        32'd12);
    tbl[12] = mk(0, 7, 1,1,1, 16'd2,    32'h0,        26'd0,      32'h0,        32'd4);
    tbl[13] = mk(0, 2, 0,0,0, 16'd2,    32'h0,        26'd0,      32'h0,        32'd4);
    tbl[14] = mk(0, 0, 0,0,0, 16'h0000, 32'h0,        26'd0,      32'hFFFFFFFC, 32'h0);
    tbl[15] = mk(0, 1, 0,0,0, 16'hFFFE, 32'h0,        26'd0,      32'h0,        32'hFFFFFFFC);
    tbl[16] = mk(1, 0, 0,0,0, 16'h0000, 32'h0,        26'h3FFFFFF,32'hF0000000, 32'hFFFFFFFC);
    tbl[17] = mk(1, 0, 0,0,0, 16'h0000, 32'h0,        26'd1,      32'hEFFFFFFC, 32'hF0000004);
    tbl[18] = mk(2, 1, 0,0,0, 16'd71,   32'h12345677, 26'd0,      32'h0,        32'h12345677);
    tbl[19] = mk(1, 1, 1,1,1, 16'd71,   32'h0,        26'd0,      32'h0,        32'h0);

    step(mk(2, 1, 1,1,1, 16'h1234, 32'hDEADBEEF, 26'd5, 32'h40, 32'h0), 1'b1, "reset");

    for (int i = 0; i < NV; i++) step(tbl[i], 1'b0, $sformatf("vec%0d", i));

    // Hold keeps the last registered value across several edges.
    step(tbl[5], 1'b0, "hold_load");
    step(mk(3, 1, 1,1,1, 16'd71, 32'hDEADBEEF, 26'd7, 32'h2000, 32'd100), 1'b0, "hold1");
    step(mk(3, 0, 0,0,0, 16'd0,  32'h0,        26'd0, 32'h0,    32'd100), 1'b0, "hold2");

    // Reset mid-sequence discards a pending jump; hold afterwards keeps zero; then normal update.
    step(mk(2, 0, 0,0,0, 16'd0, 32'hDEADBEEF, 26'd0, 32'h0, 32'hDEADBEEF), 1'b1, "mid_reset");
    step(mk(3, 0, 0,0,0, 16'd0, 32'hDEADBEEF, 26'd0, 32'h0, 32'h0), 1'b0, "post_reset_hold");
    step(mk(0, 0, 0,0,0, 16'd0, 32'h0,        26'd0, 32'h0, 32'd4), 1'b0, "post_reset_seq");

    if (sbq.size() != 0) begin
      tests++; fails++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
